// File: rtl/scalar_wb_queue.sv
// Writeback queue feeding the scalar register-file write port from the ALU and load unit.
// Optional macro SCALAR_WB_BYPASS_EN: an ALU result accepted while the queue is empty goes straight to we3/wa3/wd3.
module scalar_wb_queue #(
  parameter int DATA_WIDTH   = 19,
  parameter int ADDRESSWIDTH = 4,
  parameter int DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [ADDRESSWIDTH-1:0]      alu_addr,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  output logic                         alu_ready,
  input  logic                         mem_valid,
  input  logic [ADDRESSWIDTH-1:0]      mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  output logic                         mem_ready,
  output logic                         we3,
  output logic [ADDRESSWIDTH-1:0]      wa3,
  output logic [DATA_WIDTH-1:0]        wd3,
  input  logic [ADDRESSWIDTH-1:0]      chk_addr1,
  input  logic [ADDRESSWIDTH-1:0]      chk_addr2,
  output logic                         chk_hit1,
  output logic                         chk_hit2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDRESSWIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [DEPTH];

  logic [PW-1:0]           head_q, head_d, tail_q, tail_d, mem_slot;
  logic [CW-1:0]           count_q, count_d, free;
  logic                    we3_q, we3_d;
  logic [ADDRESSWIDTH-1:0] wa3_q, wa3_d;
  logic [DATA_WIDTH-1:0]   wd3_q, wd3_d;
  logic                    alu_acc, mem_acc, alu_enq, pop, bypass;

  always_comb begin
    free      = CW'(DEPTH) - count_q;
    alu_ready = !rst && (free >= CW'(1));
    mem_ready = !rst && ((free >= CW'(2)) || ((free >= CW'(1)) && !alu_valid));
    alu_acc   = alu_valid && alu_ready;
    mem_acc   = mem_valid && mem_ready;
    pop       = (count_q != '0);
`ifdef SCALAR_WB_BYPASS_EN
    bypass    = alu_acc && !pop;
`else
    bypass    = 1'b0;
`endif
    alu_enq   = alu_acc && !bypass;
    // mem lands behind the ALU entry when both are enqueued in the same cycle
    mem_slot  = tail_q + PW'(alu_enq);
    tail_d    = tail_q + PW'(alu_enq) + PW'(mem_acc);
    head_d    = head_q + PW'(pop);
    count_d   = count_q + CW'(alu_enq) + CW'(mem_acc) - CW'(pop);
    we3_d     = pop || bypass;
    wa3_d     = wa3_q;
    wd3_d     = wd3_q;
    if (bypass) begin
      wa3_d = alu_addr;
      wd3_d = alu_data;
    end else if (pop) begin
      wa3_d = addr_q[head_q];
      wd3_d = data_q[head_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we3_q   <= we3_d;
      wa3_q   <= wa3_d;
      wd3_q   <= wd3_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alu_enq) begin
      addr_q[tail_q] <= alu_addr;
      data_q[tail_q] <= alu_data;
    end
    if (mem_acc) begin
      addr_q[mem_slot] <= mem_addr;
      data_q[mem_slot] <= mem_data;
    end
  end

  // A slot is occupied when its distance from head is below count.
  always_comb begin
    chk_hit1 = we3_q && (wa3_q == chk_addr1);
    chk_hit2 = we3_q && (wa3_q == chk_addr2);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(PW'(PW'(i) - head_q)) < count_q) begin
        if (addr_q[PW'(i)] == chk_addr1) chk_hit1 = 1'b1;
        if (addr_q[PW'(i)] == chk_addr2) chk_hit2 = 1'b1;
      end
    end
    if (rst) begin
      chk_hit1 = 1'b0;
      chk_hit2 = 1'b0;
    end
  end

  assign we3   = we3_q;
  assign wa3   = wa3_q;
  assign wd3   = wd3_q;
  assign count = count_q;

endmodule

// File: tb/tb_scalar_wb_queue.sv
// Self-checking bench for scalar_wb_queue against a queue-based reference model.
module tb_scalar_wb_queue;

  localparam int DW = 19;
  localparam int AW = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid;
  logic [AW-1:0] alu_addr, mem_addr, chk_addr1, chk_addr2;
  logic [DW-1:0] alu_data, mem_data;
  logic          alu_ready, mem_ready, we3, chk_hit1, chk_hit2;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [2:0]    count;

  int n_cmp = 0;
  int n_err = 0;

  ent_t          q[$];
  logic          m_we = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic [DW-1:0] m_wd = '0;
  ent_t          wlog[$];
  int            wcyc[$];
  int            cyc = 0;

  scalar_wb_queue #(.DATA_WIDTH(DW), .ADDRESSWIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic bit m_ar();
    return !rst && (DEPTH - q.size()) >= 1;
  endfunction

  function automatic bit m_mr();
    int fr;
    fr = DEPTH - q.size();
    return !rst && (fr >= 2 || (fr >= 1 && !alu_valid));
  endfunction

  function automatic bit m_hit(input logic [AW-1:0] a);
    bit h;
    h = m_we && (m_wa == a);
    foreach (q[k]) if (q[k].a == a) h = 1'b1;
    return h && !rst;
  endfunction

  function automatic logic [30:0] m_vec();
    return {m_ar(), m_mr(), 3'(q.size()), m_we, m_wa, m_wd, m_hit(chk_addr1), m_hit(chk_addr2)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  // Advance one clock edge; the model applies the accept/retire rules for the same edge.
  task automatic tick();
    bit aa, ma, byp;
    ent_t e;
    if (!rst) begin
      aa  = alu_valid && m_ar();
      ma  = mem_valid && m_mr();
      byp = 1'b0;
`ifdef SCALAR_WB_BYPASS_EN
      byp = aa && (q.size() == 0);
`endif
      if (byp) begin
        m_we = 1'b1; m_wa = alu_addr; m_wd = alu_data;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_we = 1'b1; m_wa = e.a; m_wd = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (aa && !byp) q.push_back({alu_addr, alu_data});
      if (ma) q.push_back({mem_addr, mem_data});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (we3) begin
      wlog.push_back({wa3, wd3});
      wcyc.push_back(cyc);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (6) tick();
    wlog.delete();
    wcyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
    chk_addr1 = '0; chk_addr2 = '0;
    #3;
    n_cmp++;
    if ({count, we3, alu_ready, mem_ready, chk_hit1} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_hold got cnt=%0d we3=%b ar=%b mr=%b h1=%b exp all 0", count, we3, alu_ready, mem_ready, chk_hit1);
    end
    #9 rst = 1'b0;
    #1;
    n_cmp++;
    if (alu_ready !== 1'b1 || count !== 3'd0) begin
      n_err++;
      $display("FAIL reset_release got ar=%b cnt=%0d exp ar=1 cnt=0", alu_ready, count);
    end
    @(posedge clk); #1;
    model_reset();
    tick();
    n_cmp++;
    if (we3 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_we3 got %b exp 0", we3);
    end
  endtask

  task automatic test_reset_midstream();
    drain();
    alu_valid = 1'b1; mem_valid = 1'b1;
    alu_addr = 4'd1; alu_data = 19'h11; mem_addr = 4'd2; mem_data = 19'h22;
    tick();
    alu_addr = 4'd9; alu_data = 19'h33; mem_addr = 4'd10; mem_data = 19'h44;
    tick();
    idle_inputs();
    chk_addr1 = 4'd10;
    #1;
    n_cmp++;
    if (count !== 3'(q.size())) begin
      n_err++;
      $display("FAIL midrst_count_before got %0d exp %0d", count, q.size());
    end
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if ({count, we3, wa3, wd3, alu_ready, mem_ready, chk_hit1, chk_hit2} !== '0) begin
      n_err++;
      $display("FAIL midrst_clear got cnt=%0d we3=%b wa3=%h wd3=%h ar=%b mr=%b h1=%b h2=%b exp all 0",
               count, we3, wa3, wd3, alu_ready, mem_ready, chk_hit1, chk_hit2);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (we3 !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_nowrite cycle %0d got we3=%b exp 0", i, we3);
      end
    end
  endtask

  task automatic test_single();
    drain();
    alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 19'h1ABCD;
    tick();
    idle_inputs();
`ifndef SCALAR_WB_BYPASS_EN
    n_cmp++;
    if (we3 !== 1'b0 || count !== 3'd1) begin
      n_err++;
      $display("FAIL single_latency got we3=%b cnt=%0d exp we3=0 cnt=1", we3, count);
    end
    tick();
`endif
    n_cmp++;
    if ({we3, wa3, wd3} !== {1'b1, 4'd5, 19'h1ABCD}) begin
      n_err++;
      $display("FAIL single_write got we3=%b wa3=%0d wd3=%h exp we3=1 wa3=5 wd3=1abcd", we3, wa3, wd3);
    end
    tick();
    n_cmp++;
    if (we3 !== 1'b0) begin
      n_err++;
      $display("FAIL single_after got we3=%b exp 0", we3);
    end
  endtask

  task automatic test_same_addr();
    drain();
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 19'h00011;
    mem_valid = 1'b1; mem_addr = 4'd3; mem_data = 19'h00022;
    #1;
    n_cmp++;
    if ({alu_ready, mem_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL dual_ready got ar=%b mr=%b exp 1 1", alu_ready, mem_ready);
    end
    tick();
    idle_inputs();
    repeat (4) tick();
    n_cmp++;
    if (wlog.size() != 2 || wlog[0] !== {4'd3, 19'h00011} || wlog[1] !== {4'd3, 19'h00022}
        || wcyc[1] - wcyc[0] != 1) begin
      n_err++;
      $display("FAIL dual_order got n=%0d w0=%h w1=%h exp n=2 w0=%h w1=%h consecutive",
               wlog.size(), wlog.size() > 0 ? wlog[0] : '0, wlog.size() > 1 ? wlog[1] : '0,
               {4'd3, 19'h00011}, {4'd3, 19'h00022});
    end
  endtask

  task automatic test_fill();
    ent_t acc[$];
    drain();
    for (int i = 0; i < 7; i++) begin
      alu_valid = 1'b1; mem_valid = 1'b1;
      alu_addr = 4'($urandom_range(0, 15)); alu_data = 19'($urandom);
      mem_addr = 4'($urandom_range(0, 15)); mem_data = 19'($urandom);
      #1;
      n_cmp++;
      if ({alu_ready, mem_ready, count} !== {m_ar(), m_mr(), 3'(q.size())}) begin
        n_err++;
        $display("FAIL fill_ready cycle %0d got ar=%b mr=%b cnt=%0d exp ar=%b mr=%b cnt=%0d",
                 i, alu_ready, mem_ready, count, m_ar(), m_mr(), q.size());
      end
      if (alu_ready) acc.push_back({alu_addr, alu_data});
      if (mem_ready) acc.push_back({mem_addr, mem_data});
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b1; mem_addr = 4'd14; mem_data = 19'h5A5A5;
    #1;
    n_cmp++;
    if (count !== 3'd3 || mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL fill_mem_only got cnt=%0d mr=%b ar=%b exp cnt=3 mr=1 ar=1", count, mem_ready, alu_ready);
    end
    if (mem_ready) acc.push_back({mem_addr, mem_data});
    tick();
    idle_inputs();
    repeat (6) tick();
    n_cmp++;
    if (wlog.size() != acc.size() || wlog != acc) begin
      n_err++;
      $display("FAIL fill_order got %0d writes exp %0d in accept order", wlog.size(), acc.size());
    end
  endtask

  task automatic test_hazard();
    bit exp1[$];
`ifdef SCALAR_WB_BYPASS_EN
    exp1 = '{1'b1, 1'b0, 1'b0};
`else
    exp1 = '{1'b1, 1'b1, 1'b0};
`endif
    drain();
    chk_addr1 = 4'd7; chk_addr2 = 4'd2;
    alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 19'($urandom);
    tick();
    idle_inputs();
    foreach (exp1[k]) begin
      n_cmp++;
      if ({chk_hit1, chk_hit2} !== {exp1[k], 1'b0}) begin
        n_err++;
        $display("FAIL hazard cycle %0d got h1=%b h2=%b exp h1=%b h2=0", k, chk_hit1, chk_hit2, exp1[k]);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    drain();
    for (int i = 0; i < 10; i++) begin
      alu_valid = 1'b1; alu_addr = 4'(i % 16); alu_data = 19'(i);
      tick();
    end
    idle_inputs();
    repeat (4) tick();
    n_cmp++;
    if (wlog.size() != 10 || wcyc[wcyc.size()-1] - wcyc[0] != 9) begin
      n_err++;
      $display("FAIL wrap_stream got %0d writes exp 10 contiguous", wlog.size());
    end
    for (int i = 0; i < 10 && i < wlog.size(); i++) begin
      n_cmp++;
      if (wlog[i] !== {4'(i % 16), 19'(i)}) begin
        n_err++;
        $display("FAIL wrap_entry %0d got %h exp %h", i, wlog[i], {4'(i % 16), 19'(i)});
      end
    end
    n_cmp++;
    if (count !== 3'd0) begin
      n_err++;
      $display("FAIL wrap_count got %0d exp 0", count);
    end
  endtask

  task automatic test_random();
    logic [30:0] got, exp;
    drain();
    for (int i = 0; i < 400; i++) begin
      alu_valid = ($urandom_range(0, 3) != 0);
      mem_valid = ($urandom_range(0, 2) != 0);
      alu_addr = 4'($urandom_range(0, 15)); alu_data = 19'($urandom);
      mem_addr = 4'($urandom_range(0, 15)); mem_data = 19'($urandom);
      chk_addr1 = 4'($urandom_range(0, 15)); chk_addr2 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
      end
      #1;
      got = {alu_ready, mem_ready, count, we3, wa3, wd3, chk_hit1, chk_hit2};
      exp = m_vec();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random cycle %0d got ar,mr,cnt,we,wa,wd,h1,h2=%h exp %h", i, got, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_single();
    test_same_addr();
    test_fill();
    test_hazard();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scalar_wb_queue.md
# scalar_wb_queue

Writeback stage feeding the scalar register file write port (`we3`/`wa3`/`wd3`). Accepts results from two producers, the scalar ALU and the load unit, each with a valid/ready handshake. Results are buffered in an in-order FIFO and retired one per cycle into registered write-port outputs. A hazard lookup port tells decode whether a source register still has a write pending.

## Interface
- DATA_WIDTH, 19, width of each result word
- ADDRESSWIDTH, 4, register address width
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result present
- alu_addr  in  ADDRESSWIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
- mem_valid  in  1  load result present
- mem_addr  in  ADDRESSWIDTH  load destination register
- mem_data  in  DATA_WIDTH  load result
- mem_ready  out  1  load result accepted this cycle when high with mem_valid
- we3  out  1  register-file write enable (registered)
- wa3  out  ADDRESSWIDTH  register-file write address (registered)
- wd3  out  DATA_WIDTH  register-file write data (registered)
- chk_addr1, chk_addr2  in  ADDRESSWIDTH  decode source registers to check
- chk_hit1, chk_hit2  out  1  pending write to corresponding chk_addr
- count  out  $clog2(DEPTH+1)  occupied FIFO entries

## Operation
- Free space: free = DEPTH − count, taken from the registered count. A pop in the same cycle does not add space.
- Ready rules:
  - alu_ready = (free ≥ 1).
  - mem_ready = (free ≥ 2) or (free ≥ 1 and !alu_valid).
  - The ALU has priority; readies depend only on count and alu_valid.
- Enqueue order: when both sources are accepted in one cycle, the ALU entry is written at the tail first, then the mem entry. The later mem write to the same address therefore wins in the register file.
- Dequeue: every cycle the FIFO is non-empty at the clock edge, the head pops into the output register: we3←1, wa3←head addr, wd3←head data. When the FIFO is empty, we3←0 and wa3/wd3 hold their values.
- Pointers: head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Count update per edge: count_next = count + accepted (0..2) − popped (0/1). It never exceeds DEPTH; full ⇒ both readies low.
- Hazard check, combinational: chk_hitN = 1 if chk_addrN equals the address of any occupied FIFO entry, or if (we3 and wa3 == chk_addrN). Entries being offered on alu/mem in the same cycle are not checked.
- Reset, asynchronous, including mid-operation:
  - Clears count, head and tail to 0, and we3, wa3, wd3 to 0.
  - Drops all queued entries.
  - Holds alu_ready, mem_ready, chk_hit1 and chk_hit2 low while rst is high.

## Timing
- Without bypass:
  - A result accepted at edge N with the FIFO otherwise empty appears on we3/wa3/wd3 after edge N+1.
  - The register file captures it at edge N+2.
- Throughput is one retirement per cycle. Two accepts per cycle are allowed while free ≥ 2.
- After reset deassertion, alu_ready is high in the first cycle; we3 stays low until a result is accepted.

## Configuration
- SCALAR_WB_BYPASS_EN defined:
  - When count == 0 and the ALU result is accepted at edge N, it goes directly to we3/wa3/wd3 at edge N, skipping the FIFO.
  - If mem is also accepted in that cycle, the mem entry is enqueued and retires at edge N+1.
  - The bypassed entry counts toward chk_hit only through the we3/wa3 term.
- Undefined: every result goes through the FIFO, with the latency given in Timing.

## Test plan
- Reset mid-stream with 3 entries queued: count=0, we3=0, wa3=0, wd3=0 immediately; no further writes after rst deasserts.
- Single ALU result, addr 5, data 0x1ABCD, accepted at edge 0: we3=1, wa3=5, wd3=0x1ABCD after edge 1 (after edge 0 with SCALAR_WB_BYPASS_EN); we3=0 the following cycle.
- ALU (addr 3, 0x00011) and mem (addr 3, 0x00022) valid in the same cycle, empty FIFO: both accepted; consecutive writes 0x00011 then 0x00022 to r3.
- Fill to DEPTH=4 with alu_valid held high: alu_ready=0 when count=4; with alu_valid low and count=3, mem_ready=1; no entry lost, writeback order preserved.
- Hazard: queue a write to r7 and check chk_addr1=7, chk_addr2=2: chk_hit1=1, chk_hit2=0; chk_hit1 falls the cycle after r7 leaves wa3.
- Pointer wrap: stream 10 ALU results with data 0..9 to addr (i mod 16): outputs appear in order with no gaps beyond the latency, and count returns to 0.
